// File: rtl/custom_insn_pkg.sv
// Shared types and widths for the custom-instruction scheduler.
package custom_insn_pkg;

    localparam int OP_W   = 64;
    localparam int ADDR_W = 32;
    localparam int BE_W   = 8;
    localparam int ID_W   = 3;   // requester id, N up to 8
    localparam int CNT_W  = 3;   // outstanding count, MAX_OUTST up to 7

    typedef struct packed {
        logic [OP_W-1:0]   c_in1;
        logic [OP_W-1:0]   c_in2;
        logic [ADDR_W-1:0] addr;
        logic [BE_W-1:0]   be;
    } cins_req_t;

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } cins_tag_t;

endpackage

// File: rtl/custom_insn_sched_rr_arbiter.sv
// Pointer-based round-robin arbiter: grants the first request at/after the
// pointer when enabled, then moves the pointer just past the winner.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic             gnt_vld,
    output logic [IDX_W-1:0] gnt_idx
);

    logic [IDX_W-1:0] ptr_q, ptr_d;

    always_comb begin
        int idx;
        idx     = 0;
        gnt     = '0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        ptr_d   = ptr_q;
        if (en) begin
            for (int k = 0; k < N; k++) begin
                idx = int'(ptr_q) + k;
                if (idx >= N) idx = idx - N;
                if (!gnt_vld && req[idx]) begin
                    gnt[idx] = 1'b1;
                    gnt_vld  = 1'b1;
                    gnt_idx  = IDX_W'(idx);
                    ptr_d    = (idx == N - 1) ? '0 : IDX_W'(idx + 1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/custom_insn_sched.sv
// Shares one |a-b| custom-instruction unit among N requesters: round-robin grant,
// per-requester credit limit, tag pipe for response routing. Perf counters: CUSTOM_SCHED_PERF_EN.
module custom_insn_sched
    import custom_insn_pkg::*;
#(
    parameter int N         = 4,
    parameter int LAT       = 1,
    parameter int MAX_OUTST = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N-1:0]        m_req_vld,
    output logic [N-1:0]        m_req_rdy,
    input  logic [N*OP_W-1:0]   m_c_in1,
    input  logic [N*OP_W-1:0]   m_c_in2,
    input  logic [N*ADDR_W-1:0] m_req_addr,
    input  logic [N*BE_W-1:0]   m_req_be,
    output logic [N-1:0]        m_rsp_vld,
    output logic [OP_W-1:0]     m_rsp_res,
    output logic [ADDR_W-1:0]   m_rsp_addr,
    output logic [BE_W-1:0]     m_rsp_be,
    output logic                u_req_vld,
    input  logic                u_req_rdy,
    output logic [OP_W-1:0]     u_c_in1,
    output logic [OP_W-1:0]     u_c_in2,
    output logic [ADDR_W-1:0]   u_req_addr,
    output logic [BE_W-1:0]     u_req_be,
    input  logic                u_rsp_vld,
    input  logic [OP_W-1:0]     u_rsp_res,
    input  logic [ADDR_W-1:0]   u_rsp_addr,
    input  logic [BE_W-1:0]     u_rsp_be,
    output logic                err
`ifdef CUSTOM_SCHED_PERF_EN
    ,
    output logic [N*16-1:0]     perf_grant_cnt,
    output logic [15:0]         perf_stall_cnt
`endif
);

    localparam int IDX_W = $clog2(N);

    logic [N-1:0]     elig, gnt, dec;
    logic             gnt_vld, issue_en, rsp_fire;
    logic [IDX_W-1:0] gnt_idx;
    cins_req_t        req_sel, issue_q;
    logic             u_req_vld_q;
    logic [ID_W-1:0]  issue_id_q;
    cins_tag_t        tag_q [LAT];
    cins_tag_t        tail;
    logic [CNT_W-1:0] cnt_q [N];
    logic [N-1:0]     rsp_vld_q;
    logic [OP_W-1:0]  rsp_res_q;
    logic [ADDR_W-1:0] rsp_addr_q;
    logic [BE_W-1:0]  rsp_be_q;
    logic             err_q;

    // A new grant may only land when the issue register is free or draining this cycle.
    assign issue_en = !u_req_vld_q || u_req_rdy;

    always_comb begin
        elig = '0;
        for (int i = 0; i < N; i++)
            elig[i] = m_req_vld[i] && (cnt_q[i] < CNT_W'(MAX_OUTST));
    end

    rr_arbiter #(.N(N)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (issue_en),
        .req     (elig),
        .gnt     (gnt),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    assign m_req_rdy = gnt;

    always_comb begin
        req_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                req_sel.c_in1 = m_c_in1[i*OP_W +: OP_W];
                req_sel.c_in2 = m_c_in2[i*OP_W +: OP_W];
                req_sel.addr  = m_req_addr[i*ADDR_W +: ADDR_W];
                req_sel.be    = m_req_be[i*BE_W +: BE_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            u_req_vld_q <= 1'b0;
            issue_q     <= '0;
            issue_id_q  <= '0;
        end else if (gnt_vld) begin
            u_req_vld_q <= 1'b1;
            issue_q     <= req_sel;
            issue_id_q  <= ID_W'(gnt_idx);
        end else if (u_req_rdy) begin
            u_req_vld_q <= 1'b0;
        end
    end

    assign u_req_vld  = u_req_vld_q;
    assign u_c_in1    = issue_q.c_in1;
    assign u_c_in2    = issue_q.c_in2;
    assign u_req_addr = issue_q.addr;
    assign u_req_be   = issue_q.be;

    // Tag pipe mirrors the unit's fixed latency; stalled cycles shift in bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LAT; k++) tag_q[k] <= '0;
        end else begin
            tag_q[0].vld <= u_req_vld_q && u_req_rdy;
            tag_q[0].id  <= issue_id_q;
            for (int k = 1; k < LAT; k++) tag_q[k] <= tag_q[k-1];
        end
    end

    assign tail     = tag_q[LAT-1];
    assign rsp_fire = u_rsp_vld && tail.vld;

    always_comb begin
        dec = '0;
        for (int i = 0; i < N; i++)
            dec[i] = rsp_fire && (tail.id == ID_W'(i));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (gnt[i] && !dec[i])      cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                else if (!gnt[i] && dec[i]) cnt_q[i] <= cnt_q[i] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_vld_q  <= '0;
            rsp_res_q  <= '0;
            rsp_addr_q <= '0;
            rsp_be_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            rsp_vld_q <= dec;
            if (rsp_fire) begin
                rsp_res_q  <= u_rsp_res;
                rsp_addr_q <= u_rsp_addr;
                rsp_be_q   <= u_rsp_be;
            end
            if (u_rsp_vld && !tail.vld) err_q <= 1'b1;
        end
    end

    assign m_rsp_vld  = rsp_vld_q;
    assign m_rsp_res  = rsp_res_q;
    assign m_rsp_addr = rsp_addr_q;
    assign m_rsp_be   = rsp_be_q;
    assign err        = err_q;

`ifdef CUSTOM_SCHED_PERF_EN
    logic [15:0] perf_gnt_q [N];
    logic [15:0] perf_stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) perf_gnt_q[i] <= '0;
            perf_stall_q <= '0;
        end else begin
            for (int i = 0; i < N; i++)
                if (gnt[i]) perf_gnt_q[i] <= perf_gnt_q[i] + 16'd1;
            if ((|elig) && !u_req_rdy) perf_stall_q <= perf_stall_q + 16'd1;
        end
    end

    always_comb begin
        perf_grant_cnt = '0;
        for (int i = 0; i < N; i++) perf_grant_cnt[i*16 +: 16] = perf_gnt_q[i];
    end

    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_custom_insn_sched.sv
// Bench for custom_insn_sched: directed scenarios then random traffic, all checked
// each cycle against a transaction-level model (grant order, credits, response queue).
module tb_custom_insn_sched;

    localparam int N         = 4;
    localparam int LAT       = 1;
    localparam int MAX_OUTST = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [N-1:0]      m_req_vld, m_req_rdy, m_rsp_vld;
    logic [N*64-1:0]   m_c_in1, m_c_in2;
    logic [N*32-1:0]   m_req_addr;
    logic [N*8-1:0]    m_req_be;
    logic [63:0]       m_rsp_res;
    logic [31:0]       m_rsp_addr;
    logic [7:0]        m_rsp_be;
    logic              u_req_vld;
    logic              u_req_rdy = 1'b1;
    logic [63:0]       u_c_in1, u_c_in2;
    logic [31:0]       u_req_addr;
    logic [7:0]        u_req_be;
    logic              u_rsp_vld;
    logic [63:0]       u_rsp_res;
    logic [31:0]       u_rsp_addr;
    logic [7:0]        u_rsp_be;
    logic              err;
`ifdef CUSTOM_SCHED_PERF_EN
    logic [N*16-1:0]   perf_grant_cnt;
    logic [15:0]       perf_stall_cnt;
`endif

    custom_insn_sched #(.N(N), .LAT(LAT), .MAX_OUTST(MAX_OUTST)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_req_vld(m_req_vld), .m_req_rdy(m_req_rdy),
        .m_c_in1(m_c_in1), .m_c_in2(m_c_in2), .m_req_addr(m_req_addr), .m_req_be(m_req_be),
        .m_rsp_vld(m_rsp_vld), .m_rsp_res(m_rsp_res), .m_rsp_addr(m_rsp_addr), .m_rsp_be(m_rsp_be),
        .u_req_vld(u_req_vld), .u_req_rdy(u_req_rdy),
        .u_c_in1(u_c_in1), .u_c_in2(u_c_in2), .u_req_addr(u_req_addr), .u_req_be(u_req_be),
        .u_rsp_vld(u_rsp_vld), .u_rsp_res(u_rsp_res), .u_rsp_addr(u_rsp_addr), .u_rsp_be(u_rsp_be),
        .err(err)
`ifdef CUSTOM_SCHED_PERF_EN
        , .perf_grant_cnt(perf_grant_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] absd(input logic [63:0] a, input logic [63:0] b);
        return (a > b) ? a - b : b - a;
    endfunction

    // Requester-side stimulus state
    logic        rq_v    [N];
    logic [63:0] rq_a    [N];
    logic [63:0] rq_b    [N];
    logic [31:0] rq_addr [N];
    logic [7:0]  rq_be   [N];
    logic        inj = 1'b0;
    int          mode;

    always_comb begin
        m_req_vld  = '0;
        m_c_in1    = '0;
        m_c_in2    = '0;
        m_req_addr = '0;
        m_req_be   = '0;
        for (int i = 0; i < N; i++) begin
            m_req_vld[i]          = rq_v[i];
            m_c_in1[i*64 +: 64]   = rq_a[i];
            m_c_in2[i*64 +: 64]   = rq_b[i];
            m_req_addr[i*32 +: 32] = rq_addr[i];
            m_req_be[i*8 +: 8]    = rq_be[i];
        end
    end

    // Custom-instruction unit: fixed LAT-cycle pipeline of |a-b|
    logic        uv_q    [LAT];
    logic [63:0] ures_q  [LAT];
    logic [31:0] uaddr_q [LAT];
    logic [7:0]  ube_q   [LAT];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LAT; k++) begin
                uv_q[k] <= 1'b0; ures_q[k] <= '0; uaddr_q[k] <= '0; ube_q[k] <= '0;
            end
        end else begin
            uv_q[0]    <= u_req_vld && u_req_rdy;
            ures_q[0]  <= absd(u_c_in1, u_c_in2);
            uaddr_q[0] <= u_req_addr;
            ube_q[0]   <= u_req_be;
            for (int k = 1; k < LAT; k++) begin
                uv_q[k] <= uv_q[k-1]; ures_q[k] <= ures_q[k-1];
                uaddr_q[k] <= uaddr_q[k-1]; ube_q[k] <= ube_q[k-1];
            end
        end
    end

    assign u_rsp_vld  = uv_q[LAT-1] | inj;
    assign u_rsp_res  = ures_q[LAT-1];
    assign u_rsp_addr = uaddr_q[LAT-1];
    assign u_rsp_be   = ube_q[LAT-1];

    // Reference model: RR pointer, credits, one-deep issue slot, ordered response queue
    typedef struct {
        int          due;
        int          id;
        logic [63:0] res;
        logic [31:0] addr;
        logic [7:0]  be;
    } rsp_t;

    int          ptr;
    int          cnt [N];
    logic        slot_v;
    int          slot_id;
    logic [63:0] slot_res;
    logic [31:0] slot_addr;
    logic [7:0]  slot_be;
    rsp_t        rspq [$];
    logic        err_exp;
    int          cyc;
    logic [N-1:0] last_gnt;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ptr = 0;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        slot_v  = 1'b0;
        slot_id = 0;
        rspq.delete();
        err_exp = 1'b0;
    endtask

    task automatic new_req(input int i);
        int sel;
        sel        = $urandom_range(0, 7);
        rq_v[i]    = 1'b1;
        rq_a[i]    = {$urandom, $urandom};
        rq_b[i]    = {$urandom, $urandom};
        if (sel == 0) rq_b[i] = rq_a[i];
        else if (sel == 1) begin rq_a[i] = '1; rq_b[i] = '0; end
        else if (sel == 2) begin rq_a[i] = '0; rq_b[i] = '1; end
        rq_addr[i] = $urandom;
        rq_be[i]   = 8'($urandom);
    endtask

    task automatic set_req(input int i, input logic [63:0] a, input logic [63:0] b,
                           input logic [31:0] addr, input logic [7:0] be);
        rq_v[i] = 1'b1; rq_a[i] = a; rq_b[i] = b; rq_addr[i] = addr; rq_be[i] = be;
    endtask

    // One clock: compare at negedge, advance model at posedge, then update requesters.
    task automatic cycle();
        logic [N-1:0] exp_g, exp_rv;
        logic         s_urdy, s_inj;
        int           w, i;
        logic [63:0]  w_res;
        logic [31:0]  w_addr;
        logic [7:0]   w_be;
        @(negedge clk);
        s_urdy = u_req_rdy;
        s_inj  = inj;
        w      = -1;
        w_res  = '0; w_addr = '0; w_be = '0;
        if (!slot_v || s_urdy) begin
            for (int k = 0; k < N; k++) begin
                i = (ptr + k) % N;
                if (w < 0 && rq_v[i] && cnt[i] < MAX_OUTST) w = i;
            end
        end
        exp_g = '0;
        if (w >= 0) begin
            exp_g[w] = 1'b1;
            w_res    = absd(rq_a[w], rq_b[w]);
            w_addr   = rq_addr[w];
            w_be     = rq_be[w];
        end
        check("m_req_rdy", m_req_rdy, exp_g);
        exp_rv = '0;
        if (rspq.size() > 0 && rspq[0].due == cyc) begin
            exp_rv[rspq[0].id] = 1'b1;
            check("m_rsp_res", m_rsp_res, rspq[0].res);
            check("m_rsp_addr", m_rsp_addr, rspq[0].addr);
            check("m_rsp_be", m_rsp_be, rspq[0].be);
            void'(rspq.pop_front());
        end
        check("m_rsp_vld", m_rsp_vld, exp_rv);
        check("u_req_vld", u_req_vld, slot_v);
        check("err", err, err_exp);
        last_gnt = m_req_rdy;

        @(posedge clk);
        if (rspq.size() > 0 && rspq[0].due == cyc + 1) cnt[rspq[0].id]--;
        if (slot_v && s_urdy) begin
            rspq.push_back('{due: cyc + LAT + 1, id: slot_id, res: slot_res,
                             addr: slot_addr, be: slot_be});
            slot_v = 1'b0;
        end
        if (w >= 0) begin
            slot_v = 1'b1; slot_id = w; slot_res = w_res; slot_addr = w_addr; slot_be = w_be;
            cnt[w]++;
            ptr = (w + 1) % N;
        end
        if (s_inj) err_exp = 1'b1;
        cyc++;

        #1;
        for (int j = 0; j < N; j++) begin
            if (last_gnt[j]) begin
                if (mode == 0) rq_v[j] = 1'b0;
                else if (mode == 1) new_req(j);
                else if ($urandom_range(0, 1) == 1) new_req(j);
                else rq_v[j] = 1'b0;
            end else if (!rq_v[j] && mode == 2 && $urandom_range(0, 2) == 0) begin
                new_req(j);
            end
        end
    endtask

    task automatic do_reset(input logic chk);
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) rq_v[i] = 1'b0;
        u_req_rdy = 1'b1;
        inj       = 1'b0;
        #1;
        if (chk) begin
            check("rst_m_req_rdy", m_req_rdy, '0);
            check("rst_m_rsp_vld", m_rsp_vld, '0);
            check("rst_m_rsp_res", m_rsp_res, '0);
            check("rst_u_req_vld", u_req_vld, 1'b0);
            check("rst_u_c_in1", u_c_in1, '0);
            check("rst_err", err, 1'b0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    initial begin
        logic [N-1:0] exp3 [5];
        exp3 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i < N; i++) begin
            rq_v[i] = 1'b0; rq_a[i] = '0; rq_b[i] = '0; rq_addr[i] = '0; rq_be[i] = '0;
        end
        mode = 0;
        cyc  = 0;
        last_gnt = '0;
        model_reset();
        do_reset(1'b1);

        // single request from requester 0
        set_req(0, 64'd10, 64'd3, 32'h100, 8'hFF);
        cycle();
        check("t1_grant", last_gnt, 4'b0001);
        cycle(); cycle();
        check("t1_rsp_vld", m_rsp_vld, 4'b0001);
        check("t1_res", m_rsp_res, 64'd7);
        check("t1_addr", m_rsp_addr, 32'h100);
        repeat (2) cycle();

        // requester 2: b > a, then all-ones operands
        set_req(2, 64'd3, 64'd10, 32'h200, 8'h0F);
        cycle(); cycle(); cycle();
        check("t2_rsp_vld", m_rsp_vld, 4'b0100);
        check("t2_res", m_rsp_res, 64'd7);
        set_req(2, '1, '1, 32'h204, 8'hF0);
        cycle(); cycle(); cycle();
        check("t2_max_rsp_vld", m_rsp_vld, 4'b0100);
        check("t2_max_res", m_rsp_res, 64'd0);
        repeat (2) cycle();

        // all four continuously requesting from a fresh pointer
        do_reset(1'b0);
        mode = 1;
        for (int i = 0; i < N; i++) new_req(i);
        for (int k = 0; k < 5; k++) begin
            cycle();
            check($sformatf("t3_grant%0d", k), last_gnt, exp3[k]);
        end
        mode = 0;
        repeat (15) cycle();

        // credit limit on requester 1 with the unit stalled
        mode = 1;
        new_req(1);
        cycle();
        check("t4_grant_a", last_gnt, 4'b0010);
        cycle();
        check("t4_grant_b", last_gnt, 4'b0010);
        u_req_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            check($sformatf("t4_blocked%0d", k), last_gnt, 4'b0000);
        end
        u_req_rdy = 1'b1;
        cycle();
        check("t4_regrant", last_gnt, 4'b0010);
        mode = 0;
        repeat (10) cycle();

        // stray unit response with nothing in flight
        inj = 1'b1;
        cycle();
        inj = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            check($sformatf("t5_err_hold%0d", k), err, 1'b1);
            check($sformatf("t5_no_rsp%0d", k), m_rsp_vld, 4'b0000);
        end
        do_reset(1'b1);
        check("t5_err_cleared", err, 1'b0);

        // reset with three requests in flight
        mode = 1;
        for (int i = 0; i < N; i++) new_req(i);
        cycle(); cycle(); cycle();
        check("t6_inflight_rsp", m_rsp_vld, 4'b0001);
        do_reset(1'b1);
        for (int i = 0; i < N; i++) new_req(i);
        cycle();
        check("t6_first_grant", last_gnt, 4'b0001);

        // random traffic with random unit back-pressure
        mode = 2;
        for (int k = 0; k < 400; k++) begin
            u_req_rdy = ($urandom_range(0, 3) != 0);
            cycle();
        end
        mode = 0;
        u_req_rdy = 1'b1;
        repeat (30) cycle();
        check("drain_rspq", rspq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
